// File: rtl/grid_slot_operand_join.sv
// Operand join: NUM_IN independent FIFOs whose heads are released together as one
// operand set once every enabled channel holds data; one ack pops all enabled heads.
module grid_slot_operand_join #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 3,
    parameter int DEPTH  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [NUM_IN-1:0]                      in_en,
    input  logic [NUM_IN*DATA_W-1:0]               data_in,
    input  logic [NUM_IN-1:0]                      valid_in,
    output logic [NUM_IN-1:0]                      ready_in,
    output logic [NUM_IN*DATA_W-1:0]               op_data,
    output logic                                   op_valid,
    input  logic                                   op_ack,
    output logic [NUM_IN*$clog2(DEPTH+1)-1:0]      occupancy,
    output logic                                   err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem    [NUM_IN][DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_IN];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_IN];
    logic [CNT_W-1:0]  r_cnt    [NUM_IN];
    logic              r_err;

    logic [NUM_IN-1:0] w_full;
    logic [NUM_IN-1:0] w_have;
    logic [NUM_IN-1:0] w_push;
    logic              w_pop;
    logic              w_proto_err;

    // A disabled channel never blocks the join, so it counts as "has data".
    always_comb begin
        w_full    = '0;
        w_have    = '0;
        op_data   = '0;
        occupancy = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_full[i] = (r_cnt[i] == CNT_W'(DEPTH));
            w_have[i] = (r_cnt[i] != '0) | ~in_en[i];
            if (in_en[i])
                op_data[i*DATA_W +: DATA_W] = r_mem[i][r_rd_ptr[i]];
            occupancy[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign op_valid    = ~rst & (|in_en) & (&w_have);
    assign ready_in    = in_en & ~w_full & {NUM_IN{~rst & ~flush}};
    assign w_push      = valid_in & ready_in;
    assign w_pop       = op_valid & op_ack;
    assign w_proto_err = (op_ack & ~op_valid) | (|(valid_in & ~in_en));
    assign err         = r_err;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_push[i])
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                if (w_pop && in_en[i])
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                case ({w_push[i], w_pop & in_en[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (w_proto_err)
                r_err <= 1'b1;
        end
    end

    // Storage is not reset; w_push is already suppressed during rst and flush.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_push[i])
                r_mem[i][r_wr_ptr[i]] <= data_in[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_grid_slot_operand_join.sv
// Bench for grid_slot_operand_join: queue-based reference model with a per-cycle
// comparator, directed scenarios with literal expectations, then random traffic.
module tb_grid_slot_operand_join;

    localparam int DATA_W = 32;
    localparam int NUM_IN = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
    localparam int W      = NUM_IN*DATA_W;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic [NUM_IN-1:0]       in_en;
    logic [W-1:0]            data_in;
    logic [NUM_IN-1:0]       valid_in;
    logic [NUM_IN-1:0]       ready_in;
    logic [W-1:0]            op_data;
    logic                    op_valid;
    logic                    op_ack;
    logic [NUM_IN*CNT_W-1:0] occupancy;
    logic                    err;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] q [NUM_IN][$];
    logic              m_err   = 1'b0;
    logic              started = 1'b0;

    grid_slot_operand_join #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_en(in_en), .data_in(data_in),
        .valid_in(valid_in), .ready_in(ready_in), .op_data(op_data),
        .op_valid(op_valid), .op_ack(op_ack), .occupancy(occupancy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_IN-1:0] m_ready();
        logic [NUM_IN-1:0] r;
        for (int i = 0; i < NUM_IN; i++)
            r[i] = !rst && !flush && in_en[i] && (q[i].size() < DEPTH);
        return r;
    endfunction

    function automatic logic m_valid();
        logic v;
        v = !rst && (in_en != '0);
        for (int i = 0; i < NUM_IN; i++)
            if (in_en[i] && q[i].size() == 0) v = 1'b0;
        return v;
    endfunction

    // Reference model: advance the queues on every rising edge.
    always @(posedge clk) begin : model
        logic [NUM_IN-1:0] rdy;
        logic              vld;
        rdy = m_ready();
        vld = m_valid();
        started = 1'b1;
        if (rst || flush) begin
            for (int i = 0; i < NUM_IN; i++) q[i].delete();
            m_err = 1'b0;
        end else begin
            if ((op_ack && !vld) || ((valid_in & ~in_en) != '0)) m_err = 1'b1;
            for (int i = 0; i < NUM_IN; i++) begin
                if (vld && op_ack && in_en[i]) void'(q[i].pop_front());
                if (valid_in[i] && rdy[i]) q[i].push_back(data_in[i*DATA_W +: DATA_W]);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [W-1:0]            exp_data;
        logic [W-1:0]            dis_mask;
        logic [NUM_IN*CNT_W-1:0] exp_occ;
        logic                    exp_vld;
        if (started) begin
            exp_vld  = m_valid();
            exp_data = '0;
            dis_mask = '0;
            exp_occ  = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                exp_occ[i*CNT_W +: CNT_W] = CNT_W'(q[i].size());
                if (!in_en[i]) dis_mask[i*DATA_W +: DATA_W] = '1;
                else if (q[i].size() > 0) exp_data[i*DATA_W +: DATA_W] = q[i][0];
            end
            check("cmp_ready_in", W'(ready_in), W'(m_ready()));
            check("cmp_op_valid", W'(op_valid), W'(exp_vld));
            check("cmp_err", W'(err), W'(m_err));
            check("cmp_occupancy", W'(occupancy), W'(exp_occ));
            if (exp_vld) check("cmp_op_data", op_data, exp_data);
            else         check("cmp_op_data_disabled", op_data & dis_mask, '0);
        end
    end

    task automatic cyc(input logic [NUM_IN-1:0] v, input int d0, input int d1, input int d2,
                       input logic ack);
        valid_in = v;
        data_in  = {DATA_W'(d2), DATA_W'(d1), DATA_W'(d0)};
        op_ack   = ack;
        @(posedge clk);
        #1;
        valid_in = '0;
        op_ack   = 1'b0;
        #1;
    endtask

    task automatic do_flush(input logic [NUM_IN-1:0] en);
        flush = 1'b1;
        in_en = en;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_en = 3'b111; valid_in = '0; data_in = '0; op_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready_in", W'(ready_in), W'(3'b000));
        check("rst_op_valid", W'(op_valid), W'(1'b0));
        check("rst_occupancy", W'(occupancy), W'(9'd0));
        check("rst_err", W'(err), W'(1'b0));
        rst = 1'b0;
        #1;
        check("release_ready_in", W'(ready_in), W'(3'b111));

        // Staggered arrival on three channels.
        cyc(3'b001, 32'hA0, 0, 0, 1'b0);
        check("join_wait_valid", W'(op_valid), W'(1'b0));
        check("join_occ_ch0", W'(occupancy), W'({3'd0, 3'd0, 3'd1}));
        cyc(3'b000, 0, 0, 0, 1'b0);
        cyc(3'b010, 0, 32'hB0, 0, 1'b0);
        cyc(3'b000, 0, 0, 0, 1'b0);
        check("join_wait_valid2", W'(op_valid), W'(1'b0));
        cyc(3'b100, 0, 0, 32'hC0, 1'b0);
        check("join_valid", W'(op_valid), W'(1'b1));
        check("join_data", op_data, {32'hC0, 32'hB0, 32'hA0});
        cyc(3'b000, 0, 0, 0, 1'b1);
        check("join_after_pop_valid", W'(op_valid), W'(1'b0));
        check("join_after_pop_occ", W'(occupancy), W'(9'd0));

        // Disabled middle lane reads zero.
        do_flush(3'b101);
        cyc(3'b101, 5, 9, 7, 1'b0);
        check("mask_valid", W'(op_valid), W'(1'b1));
        check("mask_data", op_data, {32'd7, 32'd0, 32'd5});
        cyc(3'b000, 0, 0, 0, 1'b1);
        check("mask_empty_occ", W'(occupancy), W'(9'd0));
        check("mask_err_clean", W'(err), W'(1'b0));
        cyc(3'b010, 0, 42, 0, 1'b0);
        check("disabled_push_err", W'(err), W'(1'b1));
        check("disabled_push_occ", W'(occupancy), W'(9'd0));

        // Full FIFO, refused push, wrap-around ordering.
        do_flush(3'b001);
        check("flush_err_clear", W'(err), W'(1'b0));
        for (int k = 0; k < 4; k++) cyc(3'b001, 10 + k, 0, 0, 1'b0);
        check("full_ready", W'(ready_in), W'(3'b000));
        check("full_occ", W'(occupancy), W'({3'd0, 3'd0, 3'd4}));
        cyc(3'b001, 99, 0, 0, 1'b0);
        check("full_refuse_occ", W'(occupancy), W'({3'd0, 3'd0, 3'd4}));
        check("full_refuse_head", op_data, {64'd0, 32'd10});
        cyc(3'b001, 98, 0, 0, 1'b1);
        check("full_pop_no_pushthrough", W'(occupancy), W'({3'd0, 3'd0, 3'd3}));
        cyc(3'b001, 14, 0, 0, 1'b0);
        check("wrap_occ", W'(occupancy), W'({3'd0, 3'd0, 3'd4}));
        for (int k = 11; k <= 14; k++) begin
            check("wrap_order", op_data, {64'd0, DATA_W'(k)});
            cyc(3'b000, 0, 0, 0, 1'b1);
        end
        check("wrap_drained", W'(occupancy), W'(9'd0));

        // Steady-state push and pop every cycle.
        do_flush(3'b111);
        for (int k = 0; k < 2; k++) cyc(3'b111, 100 + k, 200 + k, 300 + k, 1'b0);
        for (int j = 0; j < 20; j++) begin
            check("stream_data", op_data, {DATA_W'(300 + j), DATA_W'(200 + j), DATA_W'(100 + j)});
            cyc(3'b111, 102 + j, 202 + j, 302 + j, 1'b1);
            check("stream_occ", W'(occupancy), W'({3'd2, 3'd2, 3'd2}));
        end

        // Ack on empty FIFOs.
        do_flush(3'b111);
        cyc(3'b000, 0, 0, 0, 1'b1);
        check("empty_ack_err", W'(err), W'(1'b1));
        check("empty_ack_occ", W'(occupancy), W'(9'd0));
        cyc(3'b111, 1, 2, 3, 1'b0);
        check("empty_ack_no_ptr_move", op_data, {32'd3, 32'd2, 32'd1});
        do_flush(3'b111);
        check("flush_err", W'(err), W'(1'b0));
        check("flush_occ", W'(occupancy), W'(9'd0));

        // Reset mid-stream.
        cyc(3'b111, 4, 5, 6, 1'b0);
        cyc(3'b111, 7, 8, 9, 1'b0);
        check("pre_rst_occ", W'(occupancy), W'({3'd2, 3'd2, 3'd2}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_occ", W'(occupancy), W'(9'd0));
        check("mid_rst_valid", W'(op_valid), W'(1'b0));
        check("mid_rst_ready", W'(ready_in), W'(3'b000));
        rst = 1'b0;
        #1;
        check("post_rst_ready", W'(ready_in), W'(3'b111));

        // Random traffic; in_en only changes alongside flush or rst.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r     = int'($urandom_range(0, 199));
            rst   = (r == 0);
            flush = (r >= 1 && r <= 4);
            if (rst || flush) in_en = NUM_IN'($urandom_range(0, 7));
            valid_in = NUM_IN'($urandom_range(0, 7)) &
                       (($urandom_range(0, 15) == 0) ? 3'b111 : in_en);
            data_in  = {$urandom, $urandom, $urandom};
            #1;
            op_ack = (op_valid && ($urandom_range(0, 9) < 6)) || ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; flush = 1'b0; valid_in = '0; op_ack = 1'b0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
